// File: rtl/canvas_buffer.sv
// 32x32 1-bit drawing canvas with DRAW / CLEAR / LOCK control and two registered read ports.
// Optional macro CANVAS_BRUSH3_EN widens the pen to a 3x3 brush clipped at the canvas edges.
module canvas_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] pen_x,
  input  logic [4:0] pen_y,
  input  logic       pen_down,
  input  logic       pen_erase,
  input  logic       clear_req,
  input  logic       submit,
  input  logic [9:0] read_addr,
  input  logic       read_enable,
  output logic       read_in_data,
  output logic       end_write,
  input  logic [9:0] disp_addr,
  output logic       disp_data,
  output logic       busy
);

  typedef enum logic [1:0] {S_DRAW, S_CLEAR, S_LOCK} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_canvas [32];
  logic [4:0]  r_row;
  logic [9:0]  r_lock_cnt;
  logic        r_pend_clr;
  logic        r_end_write;
  logic        r_read_data;
  logic        r_disp_data;

  logic        w_pen_we;
  logic        w_clr_we;
  logic        w_start_lock;
  logic        w_lock_done;
  logic [31:0] w_row_hit;
  logic [31:0] w_col_mask;

  assign w_lock_done = (r_lock_cnt == 10'd1023);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_CLEAR;
    else      r_state <= w_next_state;
  end

  // Next-state logic: clear_req outranks submit, which outranks the pen
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves it unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      S_DRAW: begin
        if (clear_req)   w_next_state = S_CLEAR;
        else if (submit) w_next_state = S_LOCK;
      end
      S_CLEAR: begin
        if (r_row == 5'd31) w_next_state = S_DRAW;
      end
      S_LOCK: begin
        if (w_lock_done) w_next_state = (r_pend_clr || clear_req) ? S_CLEAR : S_DRAW;
      end
      default: w_next_state = S_CLEAR;
    endcase
  end

  // Output / enable logic
  always_comb begin
    busy         = (r_state != S_DRAW);
    w_clr_we     = (r_state == S_CLEAR);
    w_start_lock = (r_state == S_DRAW) && !clear_req && submit;
    w_pen_we     = (r_state == S_DRAW) && !clear_req && !submit && (pen_down || pen_erase);
  end

  // Brush footprint as a row-select vector and a column mask
  always_comb begin
    w_row_hit  = '0;
    w_col_mask = '0;
    for (int i = 0; i < 32; i++) begin
      w_row_hit[i]  = (5'(i) == pen_y);
      w_col_mask[i] = (5'(i) == pen_x);
`ifdef CANVAS_BRUSH3_EN
      // 6-bit compares so that 31+1 never aliases onto 0 (edges clip, no wrap)
      w_row_hit[i]  = w_row_hit[i] || (6'(i) + 6'd1 == {1'b0, pen_y})
                                   || (6'(i) == {1'b0, pen_y} + 6'd1);
      w_col_mask[i] = w_col_mask[i] || (6'(i) + 6'd1 == {1'b0, pen_x})
                                    || (6'(i) == {1'b0, pen_x} + 6'd1);
`endif
    end
  end

  // NOTE: the canvas array has no reset branch; it is zeroed by the CLEAR sweep that reset forces.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_clr_we) begin
        r_canvas[r_row] <= '0;
      end else if (w_pen_we) begin
        for (int r = 0; r < 32; r++) begin
          if (w_row_hit[r])
            r_canvas[r] <= pen_erase ? (r_canvas[r] & ~w_col_mask) : (r_canvas[r] | w_col_mask);
        end
      end
    end
  end

  // Sequencing counters, end_write pulse and registered read ports
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row       <= '0;
      r_lock_cnt  <= '0;
      r_pend_clr  <= 1'b0;
      r_end_write <= 1'b0;
      r_read_data <= 1'b0;
      r_disp_data <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so reads below see the canvas before this edge's write.
      r_row       <= (r_state == S_CLEAR) ? r_row + 5'd1 : 5'd0;
      r_lock_cnt  <= (r_state == S_LOCK) ? r_lock_cnt + 10'd1 : 10'd0;
      if (r_state == S_LOCK && !w_lock_done) r_pend_clr <= r_pend_clr | clear_req;
      else                                   r_pend_clr <= 1'b0;
      r_end_write <= w_start_lock;
      if (read_enable) r_read_data <= r_canvas[read_addr[9:5]][read_addr[4:0]];
      r_disp_data <= r_canvas[disp_addr[9:5]][disp_addr[4:0]];
    end
  end

  assign read_in_data = r_read_data;
  assign disp_data    = r_disp_data;
  assign end_write    = r_end_write;

endmodule
